// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register with optional skid entry, flush and stall counter.
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 9,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'b00, HALF = 2'b01, FULL = 2'b11} state_e;
    logic              mv_q, mv_d, sv_q, sv_d;
    logic [DATA_W-1:0] md_q, md_d, sd_q, sd_d;
    logic [CTRL_W-1:0] mc_q, mc_d, sc_q, sc_d;
    logic [CNT_W-1:0]  st_q, st_d;
    logic              xi, xo;
    state_e            state;
    assign state     = state_e'({sv_q, mv_q});
    assign in_ready  = (SKID != 0) ? !sv_q : (out_ready || !mv_q);
    assign xi        = in_valid && in_ready;
    assign xo        = mv_q && out_ready;
    assign out_valid = mv_q;
    assign out_data  = md_q;
    assign out_ctrl  = mc_q;
    assign occupancy = 2'(mv_q) + 2'(sv_q);
    assign stall_cnt = st_q;
    always_comb begin
        mv_d = mv_q;
        sv_d = sv_q;
        md_d = md_q;
        mc_d = mc_q;
        sd_d = sd_q;
        sc_d = sc_q;
        if (flush) begin
            mv_d = 1'b0;
            sv_d = 1'b0;
            mc_d = '0;
            sc_d = '0;
        end else if (state == FULL) begin
            if (xo) begin
                md_d = sd_q;
                mc_d = sc_q;
                sv_d = 1'b0;
                sc_d = '0;
            end
        end else if (state == EMPTY || out_ready) begin
            // main is free or drains this edge: it takes the offered beat or becomes a bubble
            mv_d = in_valid;
            md_d = in_valid ? in_data : md_q;
            mc_d = in_valid ? in_ctrl : '0;
        end else if (xi) begin
            sv_d = 1'b1;
            sd_d = in_data;
            sc_d = in_ctrl;
        end
        st_d = clr_cnt ? '0 : (mv_q && !out_ready && !(&st_q)) ? st_q + CNT_W'(1) : st_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mv_q <= 1'b0;
            sv_q <= 1'b0;
            md_q <= '0;
            mc_q <= '0;
            sd_q <= '0;
            sc_q <= '0;
            st_q <= '0;
        end else begin
            mv_q <= mv_d;
            sv_q <= sv_d;
            md_q <= md_d;
            mc_q <= mc_d;
            sd_q <= sd_d;
            sc_q <= sc_d;
            st_q <= st_d;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: checks a skid (index 0) and a plain (index 1) stage against a FIFO-queue model.
module tb_pipe_stage_reg;
    localparam int DW = 32;
    localparam int CW = 9;
    localparam int CN = 4;
    localparam int SAT = (1 << CN) - 1;
    logic          clk = 1'b0, reset = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, clr_cnt = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          ir [2];
    logic          ov [2];
    logic [DW-1:0] od [2];
    logic [CW-1:0] oc [2];
    logic [1:0]    occ [2];
    logic [CN-1:0] sc [2];
    int            n_pass = 0, n_chk = 0;
    logic [DW+CW-1:0] mq [2][$];
    logic [DW-1:0]    mlast [2];
    int               mst [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(CN)) u_skid (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .in_ctrl(in_ctrl), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .out_ctrl(oc[0]), .occupancy(occ[0]), .clr_cnt(clr_cnt), .stall_cnt(sc[0]));
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(CN)) u_flow (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .in_ctrl(in_ctrl), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .out_ctrl(oc[1]), .occupancy(occ[1]), .clr_cnt(clr_cnt), .stall_cnt(sc[1]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // skid stage holds up to two beats; plain stage holds one and can pass through when drained
    function automatic logic exp_ir(input int k);
        return (k == 0) ? (mq[0].size() < 2) : (mq[1].size() == 0 || out_ready);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mlast[k] = '0;
            mst[k] = 0;
        end
    endtask

    task automatic chk_ir();
        for (int k = 0; k < 2; k++) chk($sformatf("in_ready%0d", k), 64'(ir[k]), 64'(exp_ir(k)));
    endtask

    task automatic chk_out();
        logic [DW+CW-1:0] h;
        logic             v;
        for (int k = 0; k < 2; k++) begin
            v = mq[k].size() > 0;
            h = v ? mq[k][0] : '0;
            chk($sformatf("out_valid%0d", k), 64'(ov[k]), 64'(v));
            chk($sformatf("out_data%0d", k), 64'(od[k]), 64'(v ? h[DW-1:0] : mlast[k]));
            chk($sformatf("out_ctrl%0d", k), 64'(oc[k]), 64'(h[DW+CW-1:DW]));
            chk($sformatf("occupancy%0d", k), 64'(occ[k]), 64'(mq[k].size()));
            chk($sformatf("stall_cnt%0d", k), 64'(sc[k]), 64'(mst[k]));
        end
    endtask

    task automatic mstep();
        logic r, v;
        if (reset) begin
            model_clear();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            r = exp_ir(k);
            v = mq[k].size() > 0;
            mst[k] = clr_cnt ? 0 : (v && !out_ready && mst[k] < SAT) ? mst[k] + 1 : mst[k];
            if (flush) mq[k].delete();
            else begin
                if (v && out_ready) void'(mq[k].pop_front());
                if (in_valid && r) mq[k].push_back({in_ctrl, in_data});
            end
            if (mq[k].size() > 0) mlast[k] = mq[k][0][DW-1:0];
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input logic fl, input logic clr);
        @(negedge clk);
        in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl; clr_cnt = clr;
        #1 chk_ir();
        @(posedge clk);
        mstep();
        #1 chk_out();
    endtask

    initial begin
        model_clear();
        #2 reset = 1'b1;
        #10 chk_ir();
        chk_out();
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'b1, DW'(i), 9'h1FF, 1'b1, 1'b0, 1'b0);
        chk("stream_occ", 64'(occ[0]), 64'd1);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'hA, 9'h11, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hB, 9'h22, 1'b0, 1'b0, 1'b0);
        chk("bp_ir_fall", 64'(ir[0]), 64'd0);
        drive(1'b1, 32'hC, 9'h33, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 9'h33, 1'b0, 1'b0, 1'b0);
        chk("bp_stall", 64'(sc[0]), 64'd3);
        drive(1'b1, 32'hC, 9'h33, 1'b1, 1'b0, 1'b0);
        chk("bp_b_next", 64'(od[0]), 64'hB);
        drive(1'b1, 32'hC, 9'h33, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h100, 9'h44, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h101, 9'h55, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h102, 9'h66, 1'b0, 1'b1, 1'b0);
        chk("flush_ov", 64'(ov[0]), 64'd0);
        chk("flush_oc", 64'(oc[0]), 64'd0);
        chk("flush_occ", 64'(occ[0]), 64'd0);
        chk("flush_ir", 64'(ir[0]), 64'd1);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hD00D, 9'h5, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("bubble_ov", 64'(ov[1]), 64'd0);
        chk("bubble_oc", 64'(oc[1]), 64'd0);
        chk("bubble_od", 64'(od[1]), 64'hD00D);
        drive(1'b1, 32'hE, 9'h7, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; clr_cnt = 1'b0; out_ready = 1'b0;
        #1 chk("mirror_lo", 64'(ir[1]), 64'd0);
        out_ready = 1'b1;
        #1 chk("mirror_hi", 64'(ir[1]), 64'd1);
        out_ready = 1'b0;
        #1 chk_ir();
        @(posedge clk);
        mstep();
        #1 chk_out();
        for (int i = 0; i < 20; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("sat_stall", 64'(sc[0]), 64'(SAT));
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("clr_wins", 64'(sc[0]), 64'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), DW'($urandom), CW'($urandom), ($urandom % 10) < 7,
                  ($urandom % 20) == 0, ($urandom % 30) == 0);
        drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 32'h200, 9'h1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h201, 9'h2, 1'b0, 1'b0, 1'b0);
        chk("full_occ", 64'(occ[0]), 64'd2);
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h202; out_ready = 1'b0;
        #2 reset = 1'b1;
        #1 model_clear();
        chk("arst_ov", 64'(ov[0]), 64'd0);
        chk("arst_od", 64'(od[0]), 64'd0);
        chk("arst_sc", 64'(sc[0]), 64'd0);
        chk_ir();
        chk_out();
        @(posedge clk);
        mstep();
        @(negedge clk) reset = 1'b0;
        drive(1'b1, 32'h300, 9'h3, 1'b1, 1'b0, 1'b0);
        chk("post_rst_occ", 64'(occ[0]), 64'd1);
        chk("post_rst_od", 64'(od[0]), 64'h300);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register that replaces the fixed per-stage latch blocks (IF/ID, ID/EX, EX/MEM, MEM/WB) between CPU pipeline stages. It carries a DATA_W-bit payload (PC, IR, operands, ALU result) and a CTRL_W-bit control bundle (RegWrite, MemRead, MemWrite, MemtoReg, ...). It adds a valid/ready handshake, a synchronous flush that inserts a bubble, an optional skid entry that registers the back-pressure path, and a saturating stall counter for performance debug.

## Interface
- DATA_W, default 128: payload width. Payload is not cleared on bubble.
- CTRL_W, default 9: control bundle width. Forced to 0 whenever the stage holds no valid beat.
- SKID, default 1: 0 gives a single register with combinational in_ready; 1 gives a two-entry skid with registered in_ready.
- CNT_W, default 16: stall counter width.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  upstream offers a beat.
- in_ready  out  1  stage accepts a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bundle.
- flush  in  1  synchronous kill of all held beats (branch/jump taken).
- out_valid  out  1  stage presents a valid beat.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  registered payload.
- out_ctrl  out  CTRL_W  registered control; 0 when out_valid=0.
- occupancy  out  2  beats held: 0, 1, or 2 (2 only when SKID=1).
- clr_cnt  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles.

## Operation
- Input transfer (XI): in_valid && in_ready. Output transfer (XO): out_valid && out_ready.
- SKID=0:
  - in_ready = out_ready || !out_valid.
  - On a rising clk edge with in_ready=1, the register loads: out_valid <= in_valid.
  - If in_valid=1, data and ctrl load from the inputs.
  - If in_valid=0, out_ctrl <= 0 and out_data holds its value.
- SKID=1: in_ready = !skid_valid, registered. The block has three states:
  - EMPTY: XI → HALF, main <= input.
  - HALF:
    - XI && XO → HALF, main <= input.
    - XI only → FULL, skid <= input.
    - XO only → EMPTY.
    - Otherwise hold.
  - FULL: in_ready=0. XO → HALF, main <= skid. Otherwise hold.
- The outputs always come from the main entry. Beat order is strictly FIFO, with no loss and no duplication.
- flush has the highest priority:
  - Next state is EMPTY.
  - out_valid and skid_valid become 0, and out_ctrl and skid ctrl become 0.
  - Any beat accepted in the flush cycle is discarded.
  - out_data holds its value.
- occupancy = out_valid + skid_valid.
- stall_cnt increments on every cycle with out_valid && !out_ready and saturates at 2^CNT_W-1.
  - clr_cnt has priority over the increment, so a cycle with both results in 0.
  - flush does not clear stall_cnt.

## Timing
- Reset (asynchronous, at once):
  - out_valid=0, out_data=0, out_ctrl=0.
  - Skid entry cleared.
  - occupancy=0, stall_cnt=0.
  - in_ready=1 in both modes.
- Latency: a beat accepted at edge N appears on the outputs after edge N. That is one cycle if main is empty or drains at the same edge; otherwise it waits behind main.
- Throughput: one beat per cycle in both modes while out_ready=1.
- SKID=1: in_ready falls on the cycle after the skid entry fills, so at most one extra beat is absorbed after out_ready drops.
- SKID=0: in_ready is a combinational function of out_ready and out_valid.
- Reset mid-transfer drops all beats immediately; operation resumes on the first edge after reset is deasserted.

## Test plan
- Streaming: reset, then SKID=1, in_valid=1 and out_ready=1 with in_data = 0..9, in_ctrl = 9'h1FF.
  - out_valid rises one cycle later.
  - out_data reads 0..9 on consecutive cycles; occupancy stays at 1.
- Back-pressure: stream beats A, B, C and drop out_ready for 3 cycles starting after A is presented.
  - in_ready falls one cycle after B is taken into the skid entry; C is held upstream.
  - stall_cnt=3.
  - Release gives A, B, C in order with no duplicate.
- Flush in FULL: with two beats held, assert flush for 1 cycle while in_valid=1.
  - Next cycle: out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
  - The beat offered during flush never appears on the outputs.
- Bubble with SKID=0: in_valid=0 with out_ready=1.
  - out_valid=0 and out_ctrl=0 at the next edge; out_data keeps its previous value.
  - in_ready mirrors out_ready combinationally while out_valid=1.
- Counter saturation, CNT_W=4: hold out_valid=1 with out_ready=0 for 20 cycles.
  - stall_cnt sticks at 15.
  - clr_cnt asserted together with a stall cycle gives 0.
- Asynchronous reset: assert reset between clock edges in the FULL state.
  - All outputs go to their reset values before the next edge.
  - After release, the first beat takes the EMPTY → HALF path normally.
